echo_delay_scheduler: RTL and testbench
=======================================

// Module: echo_delay_scheduler
// PURPOSE
//  Sequences the single-port delay-line RAM behind the echo effect: once per lrclk frame it reads delayed
//  L/R samples, then writes new feedback-mixed L/R samples, and advances the circular pointers.
//  Adds programmable delay length, memory clear after reset or on request, and frame-overrun detection.
//  Sits between the I2S sample registers (bclk domain) and the memory macro; the effect mixer consumes outputs.
// PARAMETERS
//  BITSIZE   16  sample width (signed two's complement)
//  ADDRLEN   16  RAM address width; addr = {ptr[ADDRLEN-2:0], ch}, ch 0 = L, 1 = R
//  FB_SHIFT  1   feedback attenuation: delayed sample >>> FB_SHIFT is added into the write data
// PORTS
//  bclk           in   1          bit clock, 64x lrclk; sole clock
//  resetn         in   1          async active-low reset
//  lrclk          in   1          frame clock, sampled on bclk
//  enable         in   1          1 = run frame sequences; 0 = bypass, no RAM access
//  clear          in   1          1-cycle pulse: restart RAM clear
//  delay_len      in   ADDRLEN-1  delay in frames, sampled at frame start
//  left_in        in   BITSIZE    current left sample
//  right_in       in   BITSIZE    current right sample
//  mem_addr       out  ADDRLEN    RAM address
//  mem_wdata      out  BITSIZE    RAM write data
//  mem_wren       out  1          RAM write enable
//  mem_rdata      in   BITSIZE    RAM read data, valid 1 cycle after read address
//  left_delayed   out  BITSIZE    delayed left sample
//  right_delayed  out  BITSIZE    delayed right sample
//  sample_valid   out  1          1-cycle pulse: delayed outputs updated
//  busy           out  1          1 while clearing
//  overrun        out  1          1-cycle pulse: frame start lost
// BEHAVIOUR
//  - Reset (async): mem_addr=0, mem_wdata=0, mem_wren=0, left/right_delayed=0, sample_valid=0, overrun=0,
//    busy=1, wr_ptr=0, delay_reg=1. State goes to CLEAR. Reset mid-sequence or mid-clear aborts it.
//  - Frame start (fs): bclk cycle in which sampled lrclk=1 and its previous sample=0. Registered detection.
//  - States: CLEAR, IDLE, RD_L, RD_R, WR_L, WR_R, ADV. All outputs are registered.
//  - CLEAR: clr_cnt 0..2^ADDRLEN-1. Each cycle: mem_addr=clr_cnt, mem_wdata=0, mem_wren=1.
//    After the last address: busy=0, go to IDLE. fs is ignored during CLEAR, with no overrun.
//  - clear pulse in any state: clr_cnt=0, go to CLEAR, busy=1 next cycle, pointers reset to 0.
//  - IDLE + fs + enable:
//    - Latch delay_reg = (delay_len==0) ? 1 : delay_len.
//    - rd_ptr = wr_ptr - delay_reg, mod 2^(ADDRLEN-1).
//    - Go to RD_L.
//  - IDLE + fs + !enable: stay IDLE, no RAM access, delayed outputs forced 0, pointers hold.
//  - Sequence, cycle numbers relative to fs = cycle 0:
//    - c1 RD_L: addr={rd_ptr,0}, wren=0.
//    - c2 RD_R: addr={rd_ptr,1}.
//    - c3 WR_L: capture dl=mem_rdata. addr={wr_ptr,0}, wren=1, wdata=sat(left_in>>>1 + dl>>>FB_SHIFT).
//    - c4 WR_R: capture dr=mem_rdata. addr={wr_ptr,1}, wren=1, wdata=sat(right_in>>>1 + dr>>>FB_SHIFT).
//    - c5 ADV: wren=0. wr_ptr++ with wrap 2^(ADDRLEN-1)-1 -> 0. Outputs update, sample_valid=1.
//    - Then IDLE.
//  - Read precedes write, so the minimum delay is 1 frame. A delay >= 2^(ADDRLEN-1) cannot be represented.
//  - Arithmetic: the sum is computed at BITSIZE+1 bits, then saturated to [-2^(BITSIZE-1), 2^(BITSIZE-1)-1].
//  - fs in any state other than IDLE or CLEAR: ignored, overrun=1 for one cycle, sequence continues.
//  - enable falling mid-sequence: the sequence completes; the next frame bypasses.
//  - Simultaneous clear and fs: clear wins, no overrun.
// TESTING
//  - ADDRLEN=4, release reset:
//    mem_wren=1 for addrs 0..15 on consecutive cycles, zero data; busy falls after the 16th write; no RAM activity after.
//  - delay_len=3, FB_SHIFT=1, left_in=1000 on frame 0, else 0:
//    left_delayed=500 at the sample_valid of frame 3; frame 6 gives 250 via feedback.
//  - FB_SHIFT=0, left_in=32767, stored 32767 -> wdata=32767 (sat).
//    left_in=-32768, stored -32768 -> wdata=-32768.
//  - Two fs 3 bclk apart -> one overrun pulse at the 2nd fs, one sample_valid, wr_ptr +1 only.
//  - delay_len=0 behaves as 1. ADDRLEN=4, delay=7: wr_ptr wraps 7->0 and the read addresses wrap correctly.
//  - enable=0: mem_wren stays 0 and outputs are 0. Assert resetn mid-WR_L -> outputs reset immediately, CLEAR restarts.

Source files
------------

// File: rtl/echo_delay_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : echo_delay_scheduler
// Brief   : Per-frame sequencer for the echo delay-line RAM: read delayed L/R,
//           write feedback-mixed L/R, advance circular pointers; RAM clear.
// Revision: 1.0
// ============================================================================
module echo_delay_scheduler #(
    parameter int BITSIZE  = 16,
    parameter int ADDRLEN  = 16,
    parameter int FB_SHIFT = 1
) (
    input  logic                      bclk,
    input  logic                      resetn,
    input  logic                      lrclk,
    input  logic                      enable,
    input  logic                      clear,
    input  logic [ADDRLEN-2:0]        delay_len,
    input  logic signed [BITSIZE-1:0] left_in,
    input  logic signed [BITSIZE-1:0] right_in,
    output logic [ADDRLEN-1:0]        mem_addr,
    output logic signed [BITSIZE-1:0] mem_wdata,
    output logic                      mem_wren,
    input  logic signed [BITSIZE-1:0] mem_rdata,
    output logic signed [BITSIZE-1:0] left_delayed,
    output logic signed [BITSIZE-1:0] right_delayed,
    output logic                      sample_valid,
    output logic                      busy,
    output logic                      overrun
);
    localparam int PW = ADDRLEN - 1;
    localparam logic [ADDRLEN-1:0] c_last_addr = '1;

    typedef enum logic [2:0] {
        S_CLEAR = 3'd0,
        S_IDLE  = 3'd1,
        S_RD_L  = 3'd2,
        S_RD_R  = 3'd3,
        S_WR_L  = 3'd4,
        S_WR_R  = 3'd5,
        S_ADV   = 3'd6
    } state_t;

    state_t                     r_state, w_state_nx;
    logic                       r_lr_s, r_lr_p, r_fs;
    logic [ADDRLEN-1:0]         r_clr_cnt, w_clr_nx;
    logic [PW-1:0]              r_wr_ptr, w_wr_nx;
    logic [PW-1:0]              r_rd_ptr, w_rd_nx;
    logic [PW-1:0]              r_delay, w_delay_nx;
    logic [PW-1:0]              w_delay_in;
    logic signed [BITSIZE-1:0]  r_dl, r_dr, w_dl_nx, w_dr_nx;
    logic [ADDRLEN-1:0]         w_addr_nx;
    logic signed [BITSIZE-1:0]  w_wdata_nx, w_left_nx, w_right_nx;
    logic                       w_wren_nx, w_valid_nx, w_busy_nx, w_ovr_nx;

    // Dry input is halved; the sum is formed one bit wider and clamped on overflow.
    function automatic logic signed [BITSIZE-1:0] mix(
        input logic signed [BITSIZE-1:0] dry,
        input logic signed [BITSIZE-1:0] fb
    );
        logic signed [BITSIZE:0] a;
        logic signed [BITSIZE:0] b;
        logic signed [BITSIZE:0] s;
        a = {dry[BITSIZE-1], dry};
        b = {fb[BITSIZE-1], fb};
        s = (a >>> 1) + (b >>> FB_SHIFT);
        if (s[BITSIZE] != s[BITSIZE-1])
            mix = s[BITSIZE] ? {1'b1, {(BITSIZE-1){1'b0}}} : {1'b0, {(BITSIZE-1){1'b1}}};
        else
            mix = s[BITSIZE-1:0];
    endfunction

    assign w_delay_in = (delay_len == '0) ? PW'(1) : delay_len;

    always_ff @(posedge bclk or negedge resetn) begin
        if (!resetn) begin
            r_state       <= S_CLEAR;
            r_lr_s        <= 1'b0;
            r_lr_p        <= 1'b0;
            r_fs          <= 1'b0;
            r_clr_cnt     <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_delay       <= PW'(1);
            r_dl          <= '0;
            r_dr          <= '0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            mem_wren      <= 1'b0;
            left_delayed  <= '0;
            right_delayed <= '0;
            sample_valid  <= 1'b0;
            busy          <= 1'b1;
            overrun       <= 1'b0;
        end else begin
            r_lr_s        <= lrclk;
            r_lr_p        <= r_lr_s;
            r_fs          <= r_lr_s & ~r_lr_p;
            r_state       <= w_state_nx;
            r_clr_cnt     <= w_clr_nx;
            r_wr_ptr      <= w_wr_nx;
            r_rd_ptr      <= w_rd_nx;
            r_delay       <= w_delay_nx;
            r_dl          <= w_dl_nx;
            r_dr          <= w_dr_nx;
            mem_addr      <= w_addr_nx;
            mem_wdata     <= w_wdata_nx;
            mem_wren      <= w_wren_nx;
            left_delayed  <= w_left_nx;
            right_delayed <= w_right_nx;
            sample_valid  <= w_valid_nx;
            busy          <= w_busy_nx;
            overrun       <= w_ovr_nx;
        end
    end

    // Each state's RAM action becomes visible on the outputs one cycle later.
    always_comb begin
        w_state_nx = r_state;
        w_clr_nx   = r_clr_cnt;
        w_wr_nx    = r_wr_ptr;
        w_rd_nx    = r_rd_ptr;
        w_delay_nx = r_delay;
        w_dl_nx    = r_dl;
        w_dr_nx    = r_dr;
        w_addr_nx  = mem_addr;
        w_wdata_nx = mem_wdata;
        w_wren_nx  = 1'b0;
        w_left_nx  = left_delayed;
        w_right_nx = right_delayed;
        w_valid_nx = 1'b0;
        w_busy_nx  = 1'b0;
        w_ovr_nx   = 1'b0;
        if (clear) begin
            w_state_nx = S_CLEAR;
            w_clr_nx   = '0;
            w_wr_nx    = '0;
            w_rd_nx    = '0;
            w_addr_nx  = '0;
            w_wdata_nx = '0;
            w_busy_nx  = 1'b1;
        end else begin
            w_ovr_nx = r_fs && (r_state != S_IDLE) && (r_state != S_CLEAR);
            case (r_state)
                S_CLEAR: begin
                    w_addr_nx  = r_clr_cnt;
                    w_wdata_nx = '0;
                    w_wren_nx  = 1'b1;
                    w_busy_nx  = 1'b1;
                    w_clr_nx   = r_clr_cnt + ADDRLEN'(1);
                    if (r_clr_cnt == c_last_addr)
                        w_state_nx = S_IDLE;
                end
                S_IDLE: begin
                    if (r_fs) begin
                        if (enable) begin
                            w_delay_nx = w_delay_in;
                            w_rd_nx    = r_wr_ptr - w_delay_in;
                            w_state_nx = S_RD_L;
                        end else begin
                            w_left_nx  = '0;
                            w_right_nx = '0;
                        end
                    end
                end
                S_RD_L: begin
                    w_addr_nx  = {r_rd_ptr, 1'b0};
                    w_state_nx = S_RD_R;
                end
                S_RD_R: begin
                    w_addr_nx  = {r_rd_ptr, 1'b1};
                    w_state_nx = S_WR_L;
                end
                S_WR_L: begin
                    w_dl_nx    = mem_rdata;
                    w_addr_nx  = {r_wr_ptr, 1'b0};
                    w_wren_nx  = 1'b1;
                    w_wdata_nx = mix(left_in, mem_rdata);
                    w_state_nx = S_WR_R;
                end
                S_WR_R: begin
                    w_dr_nx    = mem_rdata;
                    w_addr_nx  = {r_wr_ptr, 1'b1};
                    w_wren_nx  = 1'b1;
                    w_wdata_nx = mix(right_in, mem_rdata);
                    w_state_nx = S_ADV;
                end
                S_ADV: begin
                    w_wr_nx    = r_wr_ptr + PW'(1);
                    w_left_nx  = r_dl;
                    w_right_nx = r_dr;
                    w_valid_nx = 1'b1;
                    w_state_nx = S_IDLE;
                end
                default: begin
                    w_state_nx = S_CLEAR;
                    w_clr_nx   = '0;
                    w_busy_nx  = 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_echo_delay_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_echo_delay_scheduler
// Brief   : Two instances (FB_SHIFT 1 and 0) with RAM models, checked against a
//           frame-level reference of the delay line.
// Revision: 1.0
// ============================================================================
module tb_echo_delay_scheduler;
    localparam int ADDRLEN = 4;
    localparam int NPTR    = 1 << (ADDRLEN - 1);
    localparam int NWORD   = 1 << ADDRLEN;

    logic bclk = 1'b0, resetn = 1'b0, lrclk = 1'b0, enable = 1'b0, clear = 1'b0;
    logic [ADDRLEN-2:0] delay_len = '0;
    logic signed [15:0] left_in = '0, right_in = '0;
    logic [ADDRLEN-1:0] addr_a, addr_b;
    logic signed [15:0] wdata_a, wdata_b, rdata_a, rdata_b, ld_a, ld_b, rd_a, rd_b;
    logic wren_a, wren_b, sv_a, sv_b, busy_a, busy_b, ovr_a, ovr_b;
    logic signed [15:0] ram_a [NWORD];
    logic signed [15:0] ram_b [NWORD];

    int n_cmp = 0, n_bad = 0;
    int sv_cnt = 0, ovr_cnt = 0, wren_cnt = 0;
    int ref_mem [2][NWORD];
    int ref_wr;
    int exp_l [2];
    int exp_r [2];

    always #5 bclk = ~bclk;

    echo_delay_scheduler #(.BITSIZE(16), .ADDRLEN(ADDRLEN), .FB_SHIFT(1)) u_a (
        .bclk(bclk), .resetn(resetn), .lrclk(lrclk), .enable(enable), .clear(clear),
        .delay_len(delay_len), .left_in(left_in), .right_in(right_in),
        .mem_addr(addr_a), .mem_wdata(wdata_a), .mem_wren(wren_a), .mem_rdata(rdata_a),
        .left_delayed(ld_a), .right_delayed(rd_a), .sample_valid(sv_a),
        .busy(busy_a), .overrun(ovr_a));

    echo_delay_scheduler #(.BITSIZE(16), .ADDRLEN(ADDRLEN), .FB_SHIFT(0)) u_b (
        .bclk(bclk), .resetn(resetn), .lrclk(lrclk), .enable(enable), .clear(clear),
        .delay_len(delay_len), .left_in(left_in), .right_in(right_in),
        .mem_addr(addr_b), .mem_wdata(wdata_b), .mem_wren(wren_b), .mem_rdata(rdata_b),
        .left_delayed(ld_b), .right_delayed(rd_b), .sample_valid(sv_b),
        .busy(busy_b), .overrun(ovr_b));

    always @(posedge bclk) begin
        if (wren_a) ram_a[addr_a] <= wdata_a;
        rdata_a <= ram_a[addr_a];
        if (wren_b) ram_b[addr_b] <= wdata_b;
        rdata_b <= ram_b[addr_b];
    end

    always @(negedge bclk) begin
        if (sv_a)   sv_cnt   <= sv_cnt + 1;
        if (ovr_a)  ovr_cnt  <= ovr_cnt + 1;
        if (wren_a) wren_cnt <= wren_cnt + 1;
    end

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int sat_mix(int dry, int fb, int sh);
        int s;
        s = (dry >>> 1) + (fb >>> sh);
        if (s > 32767) s = 32767;
        else if (s < -32768) s = -32768;
        return s;
    endfunction

    task automatic model_clear();
        for (int u = 0; u < 2; u++)
            for (int a = 0; a < NWORD; a++) ref_mem[u][a] = 0;
        ref_wr = 0;
    endtask

    // One enabled frame of the echo: read delayed pair, store mixed pair, step pointer.
    task automatic model_frame(input int l, input int r, input int dlen);
        int d, rp;
        d  = (dlen == 0) ? 1 : dlen;
        rp = (ref_wr - d + NPTR) % NPTR;
        for (int u = 0; u < 2; u++) begin
            exp_l[u] = ref_mem[u][2*rp];
            exp_r[u] = ref_mem[u][2*rp+1];
            ref_mem[u][2*ref_wr]   = sat_mix(l, exp_l[u], (u == 0) ? 1 : 0);
            ref_mem[u][2*ref_wr+1] = sat_mix(r, exp_r[u], (u == 0) ? 1 : 0);
        end
        ref_wr = (ref_wr + 1) % NPTR;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_l_a"}, ld_a, exp_l[0]);
        chk({tag, "_r_a"}, rd_a, exp_r[0]);
        chk({tag, "_l_b"}, ld_b, exp_l[1]);
        chk({tag, "_r_b"}, rd_b, exp_r[1]);
    endtask

    task automatic run_frame(input int l, input int r, input int dlen, input string tag);
        bit got;
        got = 1'b0;
        @(negedge bclk);
        left_in = 16'(l); right_in = 16'(r); delay_len = (ADDRLEN-1)'(dlen);
        enable = 1'b1; lrclk = 1'b1;
        for (int i = 0; i < 24; i++) begin
            @(negedge bclk);
            if (i == 3) lrclk = 1'b0;
            if (sv_a) begin got = 1'b1; break; end
        end
        lrclk = 1'b0;
        chk({tag, "_valid_a"}, got, 1);
        chk({tag, "_valid_b"}, sv_b, 1);
        model_frame(l, r, dlen);
        check_outputs(tag);
        repeat (2) @(negedge bclk);
    endtask

    task automatic check_clear(input string tag);
        int n, w0;
        bit done;
        n = 0; done = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge bclk);
            if (wren_a) begin
                chk({tag, "_addr"}, addr_a, n);
                chk({tag, "_data"}, wdata_a, 0);
                n++;
            end
            if (!busy_a) begin done = 1'b1; break; end
        end
        chk({tag, "_busy_fell"}, done, 1);
        chk({tag, "_nwrites"}, n, NWORD);
        w0 = wren_cnt;
        repeat (8) @(negedge bclk);
        chk({tag, "_quiet"}, wren_cnt - w0, 0);
    endtask

    initial begin
        int w0, s0, o0, l, r;
        // Reset state
        repeat (3) @(negedge bclk);
        chk("rst_busy_a", busy_a, 1);
        chk("rst_busy_b", busy_b, 1);
        chk("rst_wren", wren_a, 0);
        chk("rst_addr", addr_a, 0);
        chk("rst_wdata", wdata_a, 0);
        chk("rst_ldel", ld_a, 0);
        chk("rst_valid", sv_a, 0);
        chk("rst_ovr", ovr_b, 0);
        resetn = 1'b1;
        model_clear();
        check_clear("init_clear");

        // Impulse through a 3-frame delay with feedback
        for (int k = 0; k < 7; k++) begin
            run_frame((k == 0) ? 1000 : 0, 0, 3, "impulse");
            if (k == 3) chk("impulse_f3", ld_a, 500);
            if (k == 6) chk("impulse_f6", ld_a, 250);
        end

        // Random data and delays, including 0 (acts as 1) and 7 (pointer wrap)
        for (int k = 0; k < 24; k++)
            run_frame($signed(16'($urandom)), $signed(16'($urandom)),
                      (k % 3 == 0) ? 7 : ((k % 5 == 0) ? 0 : int'($urandom_range(0, 7))), "rand");

        // Bypass frame: no RAM traffic, outputs forced to zero, pointers hold
        @(negedge bclk);
        w0 = wren_cnt; s0 = sv_cnt;
        enable = 1'b0; lrclk = 1'b1;
        repeat (4) @(negedge bclk);
        lrclk = 1'b0;
        repeat (12) @(negedge bclk);
        chk("bypass_wren", wren_cnt - w0, 0);
        chk("bypass_valid", sv_cnt - s0, 0);
        chk("bypass_l_a", ld_a, 0);
        chk("bypass_r_a", rd_a, 0);
        chk("bypass_l_b", ld_b, 0);
        run_frame(1234, -4321, 2, "after_bypass");

        // Two frame starts 3 cycles apart
        l = $signed(16'($urandom)); r = $signed(16'($urandom));
        o0 = ovr_cnt; s0 = sv_cnt;
        @(negedge bclk);
        left_in = 16'(l); right_in = 16'(r); delay_len = 3'd4; enable = 1'b1; lrclk = 1'b1;
        @(negedge bclk); lrclk = 1'b0;
        @(negedge bclk);
        @(negedge bclk); lrclk = 1'b1;
        @(negedge bclk); lrclk = 1'b0;
        repeat (16) @(negedge bclk);
        chk("ovr_pulses", ovr_cnt - o0, 1);
        chk("ovr_valids", sv_cnt - s0, 1);
        model_frame(l, r, 4);
        check_outputs("ovr");
        run_frame(-77, 99, 1, "after_ovr");

        // Clear request, then saturation on the FB_SHIFT=0 instance
        @(negedge bclk); clear = 1'b1;
        @(negedge bclk); clear = 1'b0;
        chk("clear_busy", busy_a, 1);
        model_clear();
        check_clear("req_clear");
        for (int k = 0; k < 4; k++) run_frame(32767, 0, 1, "sat_pos");
        chk("sat_pos_b", ld_b, 32767);
        for (int k = 0; k < 6; k++) run_frame(-32768, 0, 1, "sat_neg");
        chk("sat_neg_b", ld_b, -32768);
        for (int k = 0; k < 3; k++)
            run_frame($signed(16'($urandom)), $signed(16'($urandom)), int'($urandom_range(0, 7)), "rand2");

        // Reset while the left write is being issued
        @(negedge bclk);
        left_in = 16'sd5000; enable = 1'b1; lrclk = 1'b1;
        repeat (5) @(posedge bclk);
        #2 resetn = 1'b0;
        #1;
        chk("arst_wren", wren_a, 0);
        chk("arst_busy", busy_a, 1);
        chk("arst_addr", addr_a, 0);
        chk("arst_ldel", ld_a, 0);
        chk("arst_valid", sv_a, 0);
        @(negedge bclk); lrclk = 1'b0;
        @(negedge bclk); resetn = 1'b1;
        model_clear();
        check_clear("arst_clear");
        run_frame(2222, -2222, 1, "after_arst");
        run_frame(0, 0, 1, "after_arst2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
